id_bypass_stage: RTL
====================

// Module: id_bypass_stage
// PURPOSE
//  Registered decode stage between IF_ID and EX. Decodes the logic, shift, move and arithmetic
//  subset (R-type, ORI/XORI/ANDI/LUI, ADDI/ADDIU/SLTI/SLTIU), forwards operands from NUM_BYP
//  younger pipeline stages and stalls on load-use hazards. Drives EX through a valid/ready
//  handshake and keeps a saturating stall-cycle counter for performance monitoring.
// PARAMETERS
//  WORD_W     32  datapath width; immediates are extended to WORD_W
//  RADDR_W     5  register address width; address 0 is hardwired zero
//  EXOP_W      8  width of the {EX_HIGH_*, EX_*} operation code
//  NUM_BYP     2  bypass sources; index 0 is youngest (EX), index 1 is MEM
// PORTS
//  clk               in   1                 clock, rising edge
//  rst               in   1                 synchronous reset, active-high
//  i_flush           in   1                 kill the instruction held in the output register and the one on input
//  i_valid           in   1                 i_pc/i_inst valid from IF_ID
//  o_ready           out  1                 stage accepts i_inst this cycle
//  i_pc              in   WORD_W            instruction address
//  i_inst            in   32                instruction word
//  o_readEnableLeft  out  1                 RegFile rs read enable (combinational, from i_inst)
//  o_readEnableRight out  1                 RegFile rt read enable (combinational, from i_inst)
//  o_readAddrLeft    out  RADDR_W           rs field
//  o_readAddrRight   out  RADDR_W           rt field
//  i_readValueLeft   in   WORD_W            RegFile read data, same cycle
//  i_readValueRight  in   WORD_W            RegFile read data, same cycle
//  i_bypWe           in   NUM_BYP           source k will write a register
//  i_bypDest         in   NUM_BYP*RADDR_W   destination of source k, packed with k=0 in the LSBs
//  i_bypValue        in   NUM_BYP*WORD_W    result of source k
//  i_bypPending      in   NUM_BYP           result of source k not yet available (load)
//  o_valid           out  1                 decoded instruction valid to EX
//  i_ready           in   1                 EX accepts this cycle
//  o_pc              out  WORD_W            registered pc
//  o_exop            out  EXOP_W            registered EX op
//  o_dest            out  RADDR_W           registered destination (0 means no write)
//  o_srcLeft         out  WORD_W            registered left operand
//  o_srcRight        out  WORD_W            registered right operand
//  o_stallCount      out  32                hazard-stall cycles, saturating
// BEHAVIOUR
//  Decode: per the ISA defines. Immediates: ORI/XORI/ANDI zero-extend. ADDI/ADDIU/SLTI/SLTIU
//   sign-extend to WORD_W. LUI places {imm,16'h0} on the left operand. SLL/SRL/SRA put
//   zero-extended sa on the left and rt on the right. MTHI/MTLO/MULT/MULTU set dest=0.
//   SLTU sets dest=rd. Unknown opcode/funct decodes as NOP: {EX_HIGH_SPECIAL,EX_SPECIAL_NOP},
//   dest 0, no reads.
//  Operand select: a side whose read is disabled takes the immediate. An enabled side whose
//   address is 0 takes 0. Otherwise take the lowest k with i_bypWe[k] and
//   i_bypDest[k]==addr; with no match, take i_readValue*.
//  Hazard: the lowest-k bypass match for any enabled, nonzero source has i_bypPending[k]=1.
//   A match at a higher k that is hidden by a non-pending lower-k match is not a hazard.
//  o_ready = !rst & !i_flush & !hazard & (!o_valid | i_ready).
//  Register update, in priority order:
//   1. rst -> all outputs 0, o_exop=NOP.
//   2. i_flush -> o_valid=0, o_exop=NOP, o_dest=0.
//   3. else if (!o_valid | i_ready): o_valid <= i_valid & !hazard, loading decoded fields when set.
//      When o_valid drops, o_exop=NOP and o_dest=0.
//   4. else hold all outputs stable while o_valid & !i_ready.
//  Latency: 1 cycle from acceptance to o_valid.
//  Throughput: 1 instruction per cycle with i_ready held high.
//  o_stallCount increments when i_valid & hazard & !i_flush & !rst. It saturates at 32'hFFFFFFFF
//   and is cleared only by rst.
//  rst asserted mid-stall or mid-backpressure discards everything. The first o_valid can come
//   at the earliest 1 cycle after the cycle in which rst deasserts.
// TESTING
//  ORI $2,$1,0x8001 with $1=0x1 and no bypass -> next cycle o_srcLeft=0x1, o_srcRight=0x8001,
//   o_dest=2, op OR.
//  ADDI imm=0xFFFF -> o_srcRight=0xFFFFFFFF. LUI imm=0x1234 -> o_srcLeft=0x12340000.
//  ADD $3,$1,$2 with byp0{we,dest=1,val=0xA} and byp1{we,dest=1,val=0xB} -> left=0xA (EX wins).
//   Same case with dest=0 -> RegFile value is used.
//  byp0 pending on rs=1 for 3 cycles -> o_ready=0 for 3 cycles, 3 bubbles, o_stallCount=3.
//   Then the instruction issues once with the forwarded value.
//  i_ready=0 for 4 cycles with o_valid=1 -> outputs stable and o_ready=0. i_flush in that window
//   -> o_valid=0 next cycle, op NOP.
//  Stall counter preset near max by 2^32 stall cycles (or force) -> it stays at 0xFFFFFFFF.
//   rst mid-stall -> all outputs 0 next cycle.

Source files
------------

// File: rtl/id_bypass_stage.sv
// Registered decode stage between IF_ID and EX: decodes the logic/shift/move/arith subset,
// forwards operands from younger stages, stalls on load-use hazards and counts stall cycles.
module id_bypass_stage #(
   parameter int WORD_W  = 32,
   parameter int RADDR_W = 5,
   parameter int EXOP_W  = 8,
   parameter int NUM_BYP = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_flush,
   input  logic                       i_valid,
   output logic                       o_ready,
   input  logic [WORD_W-1:0]          i_pc,
   input  logic [31:0]                i_inst,
   output logic                       o_readEnableLeft,
   output logic                       o_readEnableRight,
   output logic [RADDR_W-1:0]         o_readAddrLeft,
   output logic [RADDR_W-1:0]         o_readAddrRight,
   input  logic [WORD_W-1:0]          i_readValueLeft,
   input  logic [WORD_W-1:0]          i_readValueRight,
   input  logic [NUM_BYP-1:0]         i_bypWe,
   input  logic [NUM_BYP*RADDR_W-1:0] i_bypDest,
   input  logic [NUM_BYP*WORD_W-1:0]  i_bypValue,
   input  logic [NUM_BYP-1:0]         i_bypPending,
   output logic                       o_valid,
   input  logic                       i_ready,
   output logic [WORD_W-1:0]          o_pc,
   output logic [EXOP_W-1:0]          o_exop,
   output logic [RADDR_W-1:0]         o_dest,
   output logic [WORD_W-1:0]          o_srcLeft,
   output logic [WORD_W-1:0]          o_srcRight,
   output logic [31:0]                o_stallCount
);

   localparam logic [EXOP_W-1:0] EX_NOP   = EXOP_W'({3'd0, 5'd0});
   localparam logic [EXOP_W-1:0] EX_AND   = EXOP_W'({3'd1, 5'd1});
   localparam logic [EXOP_W-1:0] EX_OR    = EXOP_W'({3'd1, 5'd2});
   localparam logic [EXOP_W-1:0] EX_XOR   = EXOP_W'({3'd1, 5'd3});
   localparam logic [EXOP_W-1:0] EX_NOR   = EXOP_W'({3'd1, 5'd4});
   localparam logic [EXOP_W-1:0] EX_SLL   = EXOP_W'({3'd2, 5'd1});
   localparam logic [EXOP_W-1:0] EX_SRL   = EXOP_W'({3'd2, 5'd2});
   localparam logic [EXOP_W-1:0] EX_SRA   = EXOP_W'({3'd2, 5'd3});
   localparam logic [EXOP_W-1:0] EX_MFHI  = EXOP_W'({3'd3, 5'd1});
   localparam logic [EXOP_W-1:0] EX_MTHI  = EXOP_W'({3'd3, 5'd2});
   localparam logic [EXOP_W-1:0] EX_MFLO  = EXOP_W'({3'd3, 5'd3});
   localparam logic [EXOP_W-1:0] EX_MTLO  = EXOP_W'({3'd3, 5'd4});
   localparam logic [EXOP_W-1:0] EX_ADD   = EXOP_W'({3'd4, 5'd1});
   localparam logic [EXOP_W-1:0] EX_ADDU  = EXOP_W'({3'd4, 5'd2});
   localparam logic [EXOP_W-1:0] EX_SUB   = EXOP_W'({3'd4, 5'd3});
   localparam logic [EXOP_W-1:0] EX_SUBU  = EXOP_W'({3'd4, 5'd4});
   localparam logic [EXOP_W-1:0] EX_SLT   = EXOP_W'({3'd4, 5'd5});
   localparam logic [EXOP_W-1:0] EX_SLTU  = EXOP_W'({3'd4, 5'd6});
   localparam logic [EXOP_W-1:0] EX_MULT  = EXOP_W'({3'd4, 5'd7});
   localparam logic [EXOP_W-1:0] EX_MULTU = EXOP_W'({3'd4, 5'd8});

   typedef enum logic [3:0] {
      CL_NONE, CL_SHAMT, CL_RRD, CL_MF, CL_MT, CL_MUL, CL_IZ, CL_IS, CL_LUI
   } cls_t;

   logic [5:0]         w_opc;
   logic [5:0]         w_funct;
   logic [RADDR_W-1:0] w_rs;
   logic [RADDR_W-1:0] w_rt;
   logic [RADDR_W-1:0] w_rd;
   logic [15:0]        w_imm;
   cls_t               w_cls;
   logic [EXOP_W-1:0]  w_exop;
   logic [RADDR_W-1:0] w_dest;
   logic               w_enLeft;
   logic               w_enRight;
   logic [WORD_W-1:0]  w_immLeft;
   logic [WORD_W-1:0]  w_immRight;
   logic [WORD_W:0]    w_selLeft;
   logic [WORD_W:0]    w_selRight;
   logic               w_hazard;

   logic               r_valid;
   logic [WORD_W-1:0]  r_pc;
   logic [EXOP_W-1:0]  r_exop;
   logic [RADDR_W-1:0] r_dest;
   logic [WORD_W-1:0]  r_srcLeft;
   logic [WORD_W-1:0]  r_srcRight;
   logic [31:0]        r_stallCount;

   assign w_opc   = i_inst[31:26];
   assign w_funct = i_inst[5:0];
   assign w_rs    = RADDR_W'(i_inst[25:21]);
   assign w_rt    = RADDR_W'(i_inst[20:16]);
   assign w_rd    = RADDR_W'(i_inst[15:11]);
   assign w_imm   = i_inst[15:0];

   // Returns {pending, value}; the descending scan lets the lowest (youngest) match win.
   function automatic logic [WORD_W:0] f_select(
      input logic                       en,
      input logic [RADDR_W-1:0]         addr,
      input logic [WORD_W-1:0]          imm,
      input logic [WORD_W-1:0]          rf,
      input logic [NUM_BYP-1:0]         we,
      input logic [NUM_BYP*RADDR_W-1:0] dst,
      input logic [NUM_BYP*WORD_W-1:0]  val,
      input logic [NUM_BYP-1:0]         pend
   );
      logic [WORD_W:0] res;
      res = {1'b0, rf};
      if (!en) begin
         res = {1'b0, imm};
      end else if (addr == '0) begin
         res = '0;
      end else begin
         for (int k = NUM_BYP - 1; k >= 0; k--) begin
            if (we[k] && (dst[k*RADDR_W +: RADDR_W] == addr)) begin
               res = {pend[k], val[k*WORD_W +: WORD_W]};
            end else begin
               res = res;
            end
         end
      end
      return res;
   endfunction

   // Opcode/funct to EX op and operand class.
   always_comb begin
      w_exop = EX_NOP;
      w_cls  = CL_NONE;
      case (w_opc)
         6'h00: begin
            case (w_funct)
               6'h00:   begin w_exop = EX_SLL;   w_cls = CL_SHAMT; end
               6'h02:   begin w_exop = EX_SRL;   w_cls = CL_SHAMT; end
               6'h03:   begin w_exop = EX_SRA;   w_cls = CL_SHAMT; end
               6'h04:   begin w_exop = EX_SLL;   w_cls = CL_RRD;   end
               6'h06:   begin w_exop = EX_SRL;   w_cls = CL_RRD;   end
               6'h07:   begin w_exop = EX_SRA;   w_cls = CL_RRD;   end
               6'h10:   begin w_exop = EX_MFHI;  w_cls = CL_MF;    end
               6'h11:   begin w_exop = EX_MTHI;  w_cls = CL_MT;    end
               6'h12:   begin w_exop = EX_MFLO;  w_cls = CL_MF;    end
               6'h13:   begin w_exop = EX_MTLO;  w_cls = CL_MT;    end
               6'h18:   begin w_exop = EX_MULT;  w_cls = CL_MUL;   end
               6'h19:   begin w_exop = EX_MULTU; w_cls = CL_MUL;   end
               6'h20:   begin w_exop = EX_ADD;   w_cls = CL_RRD;   end
               6'h21:   begin w_exop = EX_ADDU;  w_cls = CL_RRD;   end
               6'h22:   begin w_exop = EX_SUB;   w_cls = CL_RRD;   end
               6'h23:   begin w_exop = EX_SUBU;  w_cls = CL_RRD;   end
               6'h24:   begin w_exop = EX_AND;   w_cls = CL_RRD;   end
               6'h25:   begin w_exop = EX_OR;    w_cls = CL_RRD;   end
               6'h26:   begin w_exop = EX_XOR;   w_cls = CL_RRD;   end
               6'h27:   begin w_exop = EX_NOR;   w_cls = CL_RRD;   end
               6'h2A:   begin w_exop = EX_SLT;   w_cls = CL_RRD;   end
               6'h2B:   begin w_exop = EX_SLTU;  w_cls = CL_RRD;   end
               default: begin w_exop = EX_NOP;   w_cls = CL_NONE;  end
            endcase
         end
         6'h08:   begin w_exop = EX_ADD;  w_cls = CL_IS;   end
         6'h09:   begin w_exop = EX_ADDU; w_cls = CL_IS;   end
         6'h0A:   begin w_exop = EX_SLT;  w_cls = CL_IS;   end
         6'h0B:   begin w_exop = EX_SLTU; w_cls = CL_IS;   end
         6'h0C:   begin w_exop = EX_AND;  w_cls = CL_IZ;   end
         6'h0D:   begin w_exop = EX_OR;   w_cls = CL_IZ;   end
         6'h0E:   begin w_exop = EX_XOR;  w_cls = CL_IZ;   end
         6'h0F:   begin w_exop = EX_OR;   w_cls = CL_LUI;  end
         default: begin w_exop = EX_NOP;  w_cls = CL_NONE; end
      endcase
   end

   // Operand class to read enables, destination and immediates.
   always_comb begin
      w_dest     = '0;
      w_enLeft   = 1'b0;
      w_enRight  = 1'b0;
      w_immLeft  = '0;
      w_immRight = '0;
      case (w_cls)
         CL_SHAMT: begin w_enRight = 1'b1; w_immLeft = WORD_W'(i_inst[10:6]); w_dest = w_rd; end
         CL_RRD:   begin w_enLeft = 1'b1; w_enRight = 1'b1; w_dest = w_rd; end
         CL_MF:    begin w_dest = w_rd; end
         CL_MT:    begin w_enLeft = 1'b1; end
         CL_MUL:   begin w_enLeft = 1'b1; w_enRight = 1'b1; end
         CL_IZ:    begin w_enLeft = 1'b1; w_immRight = WORD_W'(w_imm); w_dest = w_rt; end
         CL_IS:    begin w_enLeft = 1'b1; w_immRight = {{(WORD_W-16){w_imm[15]}}, w_imm}; w_dest = w_rt; end
         CL_LUI:   begin w_immLeft = WORD_W'({w_imm, 16'h0000}); w_dest = w_rt; end
         default:  begin w_dest = '0; end
      endcase
   end

   assign w_selLeft  = f_select(w_enLeft, w_rs, w_immLeft, i_readValueLeft,
                                i_bypWe, i_bypDest, i_bypValue, i_bypPending);
   assign w_selRight = f_select(w_enRight, w_rt, w_immRight, i_readValueRight,
                                i_bypWe, i_bypDest, i_bypValue, i_bypPending);
   assign w_hazard   = w_selLeft[WORD_W] | w_selRight[WORD_W];

   assign o_readEnableLeft  = w_enLeft;
   assign o_readEnableRight = w_enRight;
   assign o_readAddrLeft    = w_rs;
   assign o_readAddrRight   = w_rt;
   assign o_ready = !rst && !i_flush && !w_hazard && (!r_valid || i_ready);

   // Output register with flush/backpressure priority and the saturating stall counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid      <= 1'b0;
         r_pc         <= '0;
         r_exop       <= EX_NOP;
         r_dest       <= '0;
         r_srcLeft    <= '0;
         r_srcRight   <= '0;
         r_stallCount <= 32'd0;
      end else begin
         if (i_valid && w_hazard && !i_flush && (r_stallCount != 32'hFFFF_FFFF)) begin
            r_stallCount <= r_stallCount + 32'd1;
         end
         if (i_flush) begin
            r_valid <= 1'b0;
            r_exop  <= EX_NOP;
            r_dest  <= '0;
         end else if (!r_valid || i_ready) begin
            r_valid <= i_valid && !w_hazard;
            if (i_valid && !w_hazard) begin
               r_pc       <= i_pc;
               r_exop     <= w_exop;
               r_dest     <= w_dest;
               r_srcLeft  <= w_selLeft[WORD_W-1:0];
               r_srcRight <= w_selRight[WORD_W-1:0];
            end else begin
               r_exop <= EX_NOP;
               r_dest <= '0;
            end
         end
      end
   end

   assign o_valid      = r_valid;
   assign o_pc         = r_pc;
   assign o_exop       = r_exop;
   assign o_dest       = r_dest;
   assign o_srcLeft    = r_srcLeft;
   assign o_srcRight   = r_srcRight;
   assign o_stallCount = r_stallCount;

endmodule
